dt_bus_mux_seq: RTL and testbench

//  Parametrised, registered successor to the one-hot Dt source mux. Takes N

---
 rtl/dt_bus_mux_seq_if.sv | 29 ++
 rtl/dt_bus_mux_seq.sv | 131 +++++++++++++
 tb/tb_dt_bus_mux_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dt_bus_mux_seq_if.sv
// Request/beat bus between the register file, dt_bus_mux_seq and the Dt write path.
// Sources and selects are active-low. out_data is true polarity.
interface dt_bus_mux_seq_if #(
  parameter int W = 8,
  parameter int N = 19
);
  logic [N*W-1:0] notSrc;
  logic [N-1:0]   notSel;
  logic [N-1:0]   notSelHi;
  logic           req_valid;
  logic           req_pair;
  logic           req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic           err_multi;
  logic           err_none;

  modport slave (
    input  notSrc, notSel, notSelHi, req_valid, req_pair, out_ready,
    output req_ready, out_valid, out_data, out_last, err_multi, err_none
  );

  modport master (
    output notSrc, notSel, notSelHi, req_valid, req_pair, out_ready,
    input  req_ready, out_valid, out_data, out_last, err_multi, err_none
  );
endinterface

// File: rtl/dt_bus_mux_seq.sv
// Registered one-hot Dt source mux: snapshots the selected source(s) on accept
// and emits one beat, or two beats (low then high) for 16-bit pair pushes.
//
//   state | meaning
//   IDLE  | no beat held, ready for a request
//   BEAT0 | low (or only) beat presented on out_data
//   BEAT1 | high beat of a pair presented on out_data
module dt_bus_mux_seq #(
  parameter int W       = 8,
  parameter int N       = 19,
  parameter int PAIR_EN = 1
) (
  input  logic                  clk,
  input  logic                  notRst,
  dt_bus_mux_seq_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t         state_q;
  logic [W-1:0]   lo_q, hi_q;
  logic           pair_q;
  logic           out_valid_q, out_last_q;
  logic [W-1:0]   out_data_q;
  logic           err_multi_q, err_none_q;

  logic [W-1:0]   lo_d, hi_d;
  logic           pair_d;
  logic           any_lo, multi_lo, any_hi, multi_hi;
  logic           hs_last, accept;

  // Wired-OR of every selected source, same as the old combinational mux.
  function automatic logic [W-1:0] sel_val(input logic [N*W-1:0] src_n,
                                           input logic [N-1:0]   sel_n);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++)
      acc = acc | (~src_n[k*W +: W] & {W{~sel_n[k]}});
    return acc;
  endfunction

  // Returns {more_than_one, at_least_one}; only a 0/1/>1 decision is needed.
  function automatic logic [1:0] sel_count(input logic [N-1:0] sel_n);
    logic any, multi;
    any   = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < N; k++) begin
      multi = multi | (any & ~sel_n[k]);
      any   = any | ~sel_n[k];
    end
    return {multi, any};
  endfunction

  always_comb begin
    lo_d                 = sel_val(bus.notSrc, bus.notSel);
    hi_d                 = sel_val(bus.notSrc, bus.notSelHi);
    pair_d               = bus.req_pair & (PAIR_EN != 0);
    {multi_lo, any_lo}   = sel_count(bus.notSel);
    {multi_hi, any_hi}   = sel_count(bus.notSelHi);
  end

  assign hs_last       = out_valid_q & bus.out_ready & out_last_q;
  assign bus.req_ready = notRst & ((state_q == IDLE) | hs_last);
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or negedge notRst) begin
    if (!notRst) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      pair_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
    end else begin
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
      if (accept) begin
        lo_q        <= lo_d;
        hi_q        <= hi_d;
        pair_q      <= pair_d;
        state_q     <= BEAT0;
        out_valid_q <= 1'b1;
        out_data_q  <= lo_d;
        out_last_q  <= ~pair_d;
        err_multi_q <= multi_lo | (pair_d & multi_hi);
        err_none_q  <= ~any_lo | (pair_d & ~any_hi);
      end else begin
        case (state_q)
          BEAT0: begin
            if (bus.out_ready) begin
              if (pair_q) begin
                state_q    <= BEAT1;
                out_data_q <= hi_q;
                out_last_q <= 1'b1;
              end else begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_last_q  <= 1'b0;
              end
            end
          end
          BEAT1: begin
            if (bus.out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.err_multi = err_multi_q;
  assign bus.err_none  = err_none_q;

endmodule

// File: tb/tb_dt_bus_mux_seq.sv
// Directed bench for dt_bus_mux_seq: single, pair, stall/snapshot, errors,
// back-to-back and reset-mid-pair sequences with hand-computed expectations.
module tb_dt_bus_mux_seq;
  localparam int W = 8;
  localparam int N = 19;

  logic clk;
  logic notRst;
  int   total;
  int   passed;

  dt_bus_mux_seq_if #(.W(W), .N(N)) bus ();

  dt_bus_mux_seq #(.W(W), .N(N), .PAIR_EN(1)) dut (
    .clk    (clk),
    .notRst (notRst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [W-1:0] val);
    bus.notSrc[k*W +: W] = ~val;
  endtask

  function automatic logic [N-1:0] sel1(input int k);
    logic [N-1:0] one;
    one = '0;
    one[k] = 1'b1;
    return ~one;
  endfunction

  logic [W-1:0] b2b_exp [4];

  initial begin
    total  = 0;
    passed = 0;
    b2b_exp[0] = 8'h11; b2b_exp[1] = 8'h22; b2b_exp[2] = 8'h33; b2b_exp[3] = 8'h44;

    notRst        = 1'b0;
    bus.notSrc    = '1;
    bus.notSel    = '1;
    bus.notSelHi  = '1;
    bus.req_valid = 1'b0;
    bus.req_pair  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data",  bus.out_data, 0);
    chk("rst_last",  bus.out_last, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_err",   {bus.err_multi, bus.err_none}, 0);
    tick();
    notRst = 1'b1;
    #1;
    chk("rel_ready", bus.req_ready, 1);

    // single request, consumer stalled for one cycle
    set_src(3, 8'h5A);
    bus.notSel    = sel1(3);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("s_valid", bus.out_valid, 1);
    chk("s_data",  bus.out_data, 8'h5A);
    chk("s_last",  bus.out_last, 1);
    chk("s_err",   {bus.err_multi, bus.err_none}, 0);
    chk("s_rdy_stall", bus.req_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    chk("s_rdy_hs", bus.req_ready, 1);
    tick();
    chk("s_idle_valid", bus.out_valid, 0);
    chk("s_idle_data",  bus.out_data, 0);

    // pair: SP low/high
    set_src(10, 8'h34);
    set_src(11, 8'h12);
    bus.notSel    = sel1(10);
    bus.notSelHi  = sel1(11);
    bus.req_pair  = 1'b1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("p0_data",  bus.out_data, 8'h34);
    chk("p0_last",  bus.out_last, 0);
    chk("p0_ready", bus.req_ready, 0);
    chk("p0_err",   {bus.err_multi, bus.err_none}, 0);
    tick();
    chk("p1_valid", bus.out_valid, 1);
    chk("p1_data",  bus.out_data, 8'h12);
    chk("p1_last",  bus.out_last, 1);
    chk("p1_ready", bus.req_ready, 1);
    tick();
    chk("p_idle", bus.out_valid, 0);

    // stall with source change after accept
    bus.req_pair  = 1'b0;
    bus.notSelHi  = '1;
    bus.out_ready = 1'b0;
    set_src(5, 8'hC3);
    bus.notSel    = sel1(5);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    set_src(5, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("st_valid", bus.out_valid, 1);
      chk("st_data",  bus.out_data, 8'hC3);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("st_data_rdy", bus.out_data, 8'hC3);
    tick();
    chk("st_consumed", bus.out_valid, 0);

    // two selects active -> OR, err_multi pulse
    set_src(0, 8'h0F);
    set_src(1, 8'hF0);
    bus.notSel    = sel1(0) & sel1(1);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("em_data",  bus.out_data, 8'hFF);
    chk("em_multi", bus.err_multi, 1);
    chk("em_none",  bus.err_none, 0);
    tick();
    chk("em_pulse", bus.err_multi, 0);

    // no select active -> 00, err_none pulse
    bus.notSel    = '1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("en_valid", bus.out_valid, 1);
    chk("en_data",  bus.out_data, 0);
    chk("en_none",  bus.err_none, 1);
    chk("en_multi", bus.err_multi, 0);
    tick();
    chk("en_pulse", bus.err_none, 0);

    // pair with empty high select flags err_none
    bus.notSel    = sel1(0);
    bus.notSelHi  = '1;
    bus.req_pair  = 1'b1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("eph_none", bus.err_none, 1);
    chk("eph_lo",   bus.out_data, 8'h0F);
    tick();
    chk("eph_hi",   bus.out_data, 0);
    chk("eph_last", bus.out_last, 1);
    tick();

    // single request ignores notSelHi for errors
    bus.req_pair  = 1'b0;
    bus.notSel    = sel1(1);
    bus.notSelHi  = '1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("esh_none", bus.err_none, 0);
    chk("esh_data", bus.out_data, 8'hF0);
    tick();

    // back-to-back single requests
    for (int i = 0; i < 4; i++) set_src(12 + i, b2b_exp[i]);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.notSel = sel1(12 + i);
      #1;
      chk("bb_ready", bus.req_ready, 1);
      tick();
      chk("bb_valid", bus.out_valid, 1);
      chk("bb_data",  bus.out_data, b2b_exp[i]);
      chk("bb_last",  bus.out_last, 1);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("bb_idle", bus.out_valid, 0);

    // reset during BEAT0 of a pair
    bus.notSel    = sel1(10);
    bus.notSelHi  = sel1(11);
    bus.req_pair  = 1'b1;
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("rp_data", bus.out_data, 8'h34);
    notRst = 1'b0;
    #1;
    chk("rp_valid_async", bus.out_valid, 0);
    chk("rp_data_async",  bus.out_data, 0);
    chk("rp_ready_async", bus.req_ready, 0);
    tick();
    notRst        = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("rp_no_hi0", bus.out_valid, 0);
    tick();
    chk("rp_no_hi1", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
